// File: rtl/wb_arb_pkg.sv
// Shared types for the register-file writeback arbiter.
// Both the arbiter top and its result FIFO import this package.
package wb_arb_pkg;

  // Width of data and pc carried in a writeback request.
  localparam int WB_XLEN = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
    logic [WB_XLEN-1:0] pc;
  } wb_req_t;

  // A slot only counts as a write when it targets a real register.
  function automatic logic is_write(
    input logic       valid,
    input logic [4:0] rd
  );
    return valid && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Synchronous FIFO holding accepted MDU writeback requests.
// Order of entry is order of exit; power-of-two depth.
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  wb_req_t       push_req,
  input  logic          pop,
  output wb_req_t       head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_req_t       mem_q [DEPTH];
  wb_req_t       mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage update: write at the tail on push.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (do_push) begin
      mem_d[wr_ptr_q] = push_req;
    end
  end

  // Pointer and occupancy update; simultaneous push/pop keeps count.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Payload flops carry no reset; occupancy guards their validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  // Control flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage and MDU.
// The pipe always wins; MDU results queue and may request a bubble.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  // Must equal WB_XLEN: the request struct width comes from the package.
  parameter int XLEN           = WB_XLEN,
  parameter int MDU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pipe_valid,
  input  logic [4:0]                        pipe_rd,
  input  logic [XLEN-1:0]                   pipe_data,
  input  logic [XLEN-1:0]                   pipe_pc,
  input  logic                              mdu_valid,
  output logic                              mdu_ready,
  input  logic [4:0]                        mdu_rd,
  input  logic [XLEN-1:0]                   mdu_data,
  input  logic [XLEN-1:0]                   mdu_pc,
  output logic                              w_enable,
  output logic [4:0]                        w_addr,
  output logic [XLEN-1:0]                   w_data,
  output logic [XLEN-1:0]                   w_pc,
  output logic                              stall_req,
  output logic [$clog2(MDU_FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                              protocol_err
);

  localparam int CW = $clog2(MDU_FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic          pipe_wr;
  logic          push;
  logic          pop;
  wb_req_t       push_req;
  wb_req_t       head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  logic            w_enable_q, w_enable_d;
  logic [4:0]      w_addr_q, w_addr_d;
  logic [XLEN-1:0] w_data_q, w_data_d;
  logic [XLEN-1:0] w_pc_q, w_pc_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            stall_q, stall_d;
  logic            perr_q, perr_d;

  assign pipe_wr   = is_write(pipe_valid, pipe_rd);
  assign mdu_ready = !full;
  assign push      = mdu_valid && mdu_ready && (mdu_rd != REG_ZERO);
  assign pop       = !pipe_wr && !empty;

  assign push_req.rd   = mdu_rd;
  assign push_req.data = mdu_data;
  assign push_req.pc   = mdu_pc;

  wb_result_fifo #(
    .DEPTH (MDU_FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  // Occupancy after this edge; drives the starvation bookkeeping.
  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Port arbitration: pipe first, then FIFO head, else idle hold.
  always_comb begin
    w_enable_d = 1'b0;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    w_pc_d     = w_pc_q;
    unique case (1'b1)
      pipe_wr: begin
        w_enable_d = 1'b1;
        w_addr_d   = pipe_rd;
        w_data_d   = pipe_data;
        w_pc_d     = pipe_pc;
      end
      pop: begin
        w_enable_d = 1'b1;
        w_addr_d   = head.rd;
        w_data_d   = head.data;
        w_pc_d     = head.pc;
      end
      default: begin
        w_enable_d = 1'b0;
      end
    endcase
  end

  // Starvation counter counts edges a queued result is passed over.
  always_comb begin
    starve_d = starve_q;
    if (pop || (count_nxt == '0)) begin
      starve_d = '0;
    end else if (starve_q < SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
    stall_d = (starve_d >= SW'(STARVE_LIMIT));
  end

  // A pipe write during a requested bubble is flagged until reset.
  always_comb begin
    perr_d = perr_q || (stall_q && pipe_wr);
  end

  // Registered write port and status with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_enable_q <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      w_pc_q     <= '0;
      starve_q   <= '0;
      stall_q    <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      w_enable_q <= w_enable_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      w_pc_q     <= w_pc_d;
      starve_q   <= starve_d;
      stall_q    <= stall_d;
      perr_q     <= perr_d;
    end
  end

  assign w_enable     = w_enable_q;
  assign w_addr       = w_addr_q;
  assign w_data       = w_data_q;
  assign w_pc         = w_pc_q;
  assign stall_req    = stall_q;
  assign fifo_count   = count;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and random bench for wb_port_arbiter.
// A queue-based model predicts every output after each edge.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int LIM   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            pipe_valid;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic [XLEN-1:0] pipe_pc;
  logic            mdu_valid;
  logic            mdu_ready;
  logic [4:0]      mdu_rd;
  logic [XLEN-1:0] mdu_data;
  logic [XLEN-1:0] mdu_pc;
  logic            w_enable;
  logic [4:0]      w_addr;
  logic [XLEN-1:0] w_data;
  logic [XLEN-1:0] w_pc;
  logic            stall_req;
  logic [1:0]      fifo_count;
  logic            protocol_err;

  int checks   = 0;
  int failures = 0;

  wb_req_t         mq[$];
  int              m_starve;
  bit              m_stall;
  bit              m_perr;
  bit              m_we;
  logic [4:0]      m_addr;
  logic [XLEN-1:0] m_data;
  logic [XLEN-1:0] m_pc;
  bit              m_acc;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .XLEN           (XLEN),
    .MDU_FIFO_DEPTH (DEPTH),
    .STARVE_LIMIT   (LIM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_valid   (pipe_valid),
    .pipe_rd      (pipe_rd),
    .pipe_data    (pipe_data),
    .pipe_pc      (pipe_pc),
    .mdu_valid    (mdu_valid),
    .mdu_ready    (mdu_ready),
    .mdu_rd       (mdu_rd),
    .mdu_data     (mdu_data),
    .mdu_pc       (mdu_pc),
    .w_enable     (w_enable),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .w_pc         (w_pc),
    .stall_req    (stall_req),
    .fifo_count   (fifo_count),
    .protocol_err (protocol_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge, updating the model from the rules, then compare.
  task automatic step();
    bit      rdy;
    bit      pw;
    bit      popped;
    wb_req_t h;
    wb_req_t n;
    rdy = (mq.size() < DEPTH);
    chk("mdu_ready", {31'b0, mdu_ready}, {31'b0, rdy});
    m_acc = mdu_valid && rdy;
    pw = pipe_valid && (pipe_rd != 5'd0);
    if (rst) begin
      mq.delete();
      m_we = 0; m_addr = '0; m_data = '0; m_pc = '0;
      m_starve = 0; m_stall = 0; m_perr = 0;
    end else begin
      if (m_stall && pw) m_perr = 1;
      popped = 0;
      if (pw) begin
        m_we = 1; m_addr = pipe_rd;
        m_data = pipe_data; m_pc = pipe_pc;
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        popped = 1;
        m_we = 1; m_addr = h.rd; m_data = h.data; m_pc = h.pc;
      end else begin
        m_we = 0;
      end
      if (m_acc && mdu_rd != 5'd0) begin
        n.rd = mdu_rd; n.data = mdu_data; n.pc = mdu_pc;
        mq.push_back(n);
      end
      if (popped || mq.size() == 0) m_starve = 0;
      else if (m_starve < LIM) m_starve++;
      m_stall = (m_starve >= LIM);
    end
    @(posedge clk);
    #1;
    chk("w_enable", {31'b0, w_enable}, {31'b0, m_we});
    chk("w_addr", {27'b0, w_addr}, {27'b0, m_addr});
    chk("w_data", w_data, m_data);
    chk("w_pc", w_pc, m_pc);
    chk("stall_req", {31'b0, stall_req}, {31'b0, m_stall});
    chk("protocol_err", {31'b0, protocol_err}, {31'b0, m_perr});
    chk("fifo_count", {30'b0, fifo_count}, mq.size());
  endtask

  task automatic set_pipe(input bit v, input logic [4:0] rd,
                          input logic [31:0] d, input logic [31:0] pc);
    pipe_valid = v; pipe_rd = rd; pipe_data = d; pipe_pc = pc;
  endtask

  task automatic set_mdu(input bit v, input logic [4:0] rd,
                         input logic [31:0] d, input logic [31:0] pc);
    mdu_valid = v; mdu_rd = rd; mdu_data = d; mdu_pc = pc;
  endtask

  initial begin
    m_starve = 0; m_stall = 0; m_perr = 0; m_we = 0;
    m_addr = '0; m_data = '0; m_pc = '0; m_acc = 0;
    rst = 1'b1;
    set_pipe(0, 0, 0, 0);
    set_mdu(0, 0, 0, 0);
    @(posedge clk);
    #1;
    step();
    chk("rst_w_enable", {31'b0, w_enable}, 32'd0);
    chk("rst_fifo_count", {30'b0, fifo_count}, 32'd0);
    rst = 1'b0;

    // Pipe only
    set_pipe(1, 5'd5, 32'hDEADBEEF, 32'h100);
    step();
    chk("t1_addr", {27'b0, w_addr}, 32'd5);
    chk("t1_data", w_data, 32'hDEADBEEF);
    chk("t1_pc", w_pc, 32'h100);
    set_pipe(0, 0, 0, 0);
    step();
    chk("t1_idle", {31'b0, w_enable}, 32'd0);

    // MDU into idle port
    set_mdu(1, 5'd7, 32'h12, 32'h200);
    step();
    chk("t2_count", {30'b0, fifo_count}, 32'd1);
    set_mdu(0, 0, 0, 0);
    step();
    chk("t2_we", {31'b0, w_enable}, 32'd1);
    chk("t2_addr", {27'b0, w_addr}, 32'd7);
    chk("t2_count0", {30'b0, fifo_count}, 32'd0);

    // Starvation
    set_pipe(1, 5'd3, 32'h33, 32'h300);
    set_mdu(1, 5'd9, 32'h99, 32'h900);
    step();
    set_mdu(0, 0, 0, 0);
    step();
    step();
    chk("t3_nostall", {31'b0, stall_req}, 32'd0);
    step();
    chk("t3_stall", {31'b0, stall_req}, 32'd1);
    set_pipe(0, 0, 0, 0);
    step();
    chk("t3_addr9", {27'b0, w_addr}, 32'd9);
    chk("t3_unstall", {31'b0, stall_req}, 32'd0);
    chk("t3_perr", {31'b0, protocol_err}, 32'd0);

    // Full buffer, ordered release
    set_pipe(1, 5'd1, 32'h11, 32'h400);
    set_mdu(1, 5'd10, 32'hA0, 32'hA00);
    step();
    set_mdu(1, 5'd11, 32'hB0, 32'hB00);
    step();
    chk("t4_full", {30'b0, fifo_count}, 32'd2);
    chk("t4_notready", {31'b0, mdu_ready}, 32'd0);
    set_mdu(1, 5'd12, 32'hC0, 32'hC00);
    set_pipe(0, 0, 0, 0);
    step();
    chk("t4_first", {27'b0, w_addr}, 32'd10);
    step();
    chk("t4_second", {27'b0, w_addr}, 32'd11);
    chk("t4_acc", {31'b0, m_acc}, 32'd1);
    set_mdu(0, 0, 0, 0);
    step();
    chk("t4_third", {27'b0, w_addr}, 32'd12);
    chk("t4_third_d", w_data, 32'hC0);

    // x0 handling
    set_pipe(1, 5'd1, 32'h11, 32'h500);
    set_mdu(1, 5'd4, 32'h44, 32'h440);
    step();
    set_mdu(0, 0, 0, 0);
    set_pipe(1, 5'd0, 32'hFF, 32'h504);
    step();
    chk("t5_we", {31'b0, w_enable}, 32'd1);
    chk("t5_addr4", {27'b0, w_addr}, 32'd4);
    set_pipe(0, 0, 0, 0);
    set_mdu(1, 5'd0, 32'h55, 32'h550);
    step();
    chk("t5_drop_cnt", {30'b0, fifo_count}, 32'd0);
    chk("t5_drop_we", {31'b0, w_enable}, 32'd0);
    set_mdu(0, 0, 0, 0);

    // Reset mid-operation
    set_pipe(1, 5'd1, 32'h11, 32'h600);
    set_mdu(1, 5'd20, 32'h20, 32'h2000);
    step();
    set_mdu(1, 5'd21, 32'h21, 32'h2100);
    step();
    chk("t6_count2", {30'b0, fifo_count}, 32'd2);
    set_mdu(0, 0, 0, 0);
    set_pipe(0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_count0", {30'b0, fifo_count}, 32'd0);
    chk("t6_addr0", {27'b0, w_addr}, 32'd0);
    chk("t6_data0", w_data, 32'd0);
    step();
    step();
    chk("t6_nowrite", {31'b0, w_enable}, 32'd0);

    // Protocol error while stalled
    set_pipe(1, 5'd3, 32'h33, 32'h700);
    set_mdu(1, 5'd9, 32'h99, 32'h900);
    step();
    set_mdu(0, 0, 0, 0);
    step();
    step();
    step();
    chk("t7_stall", {31'b0, stall_req}, 32'd1);
    step();
    chk("t7_pipe_wins", {27'b0, w_addr}, 32'd3);
    chk("t7_perr", {31'b0, protocol_err}, 32'd1);
    set_pipe(0, 0, 0, 0);
    step();
    step();
    chk("t7_sticky", {31'b0, protocol_err}, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      pipe_valid = $urandom_range(0, 1);
      if (m_stall && $urandom_range(0, 9) != 0) pipe_valid = 1'b0;
      pipe_rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_data = $urandom;
      pipe_pc = $urandom;
      mdu_valid = ($urandom_range(0, 2) != 0);
      mdu_rd = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mdu_data = $urandom;
      mdu_pc = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
